// File: rtl/instr_mem_loadable_pkg.sv
// Shared constants and state type for the loadable instruction memory.
// NOOP is the all-zeros instruction returned on any faulting fetch.
package instr_mem_loadable_pkg;

  localparam int WORD_LEN       = 16;
  localparam int MEM_CELL_SIZE  = 8;
  localparam int INSTR_MEM_SIZE = 256;

  localparam logic [WORD_LEN-1:0] NOOP = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

endpackage

// File: rtl/instr_mem_loadable_array.sv
// Plain cell array: synchronous write port, asynchronous CPI-wide read port.
// The read assembles cells big-endian; the lowest address lands in the MSBs.
module instr_mem_loadable_array #(
  parameter int CELL_W = 8,
  parameter int DEPTH  = 256,
  parameter int CPI    = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [CELL_W-1:0]     i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [CPI*CELL_W-1:0] o_rdata
);

  logic [CELL_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Index wraps modulo DEPTH; callers only use the data when a+CPI is in range.
  for (genvar k = 0; k < CPI; k++) begin : g_rd
    assign o_rdata[(CPI-1-k)*CELL_W +: CELL_W] = r_mem[i_raddr + AW'(k)];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: streaming byte loader, program-length tracking
// and a registered, bounds/alignment-checked fetch port.
//
// state | meaning
// EMPTY | no valid program; every fetch faults
// LOAD  | accepting program bytes; fetches fault
// RUN   | program loaded; fetches checked against ProgLen
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int WORD_LEN       = instr_mem_loadable_pkg::WORD_LEN,
  parameter int MEM_CELL_SIZE  = instr_mem_loadable_pkg::MEM_CELL_SIZE,
  parameter int INSTR_MEM_SIZE = instr_mem_loadable_pkg::INSTR_MEM_SIZE,
  localparam int CPI           = WORD_LEN / MEM_CELL_SIZE,
  localparam int AW            = $clog2(INSTR_MEM_SIZE)
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     LoadStart,
  input  logic                     LoadValid,
  input  logic [MEM_CELL_SIZE-1:0] LoadData,
  input  logic                     LoadLast,
  output logic                     LoadReady,
  output logic                     LoadDone,
  output logic [AW:0]              ProgLen,
  output logic                     Busy,
  input  logic                     FetchEn,
  input  logic [WORD_LEN-1:0]      Addr,
  output logic [WORD_LEN-1:0]      Instruction,
  output logic                     InstrValid,
  output logic                     FetchFault
);

  if (CPI * MEM_CELL_SIZE != WORD_LEN) begin : g_chk_cpi
    $error("WORD_LEN must be an exact multiple of MEM_CELL_SIZE");
  end
  if ((1 << AW) != INSTR_MEM_SIZE || INSTR_MEM_SIZE < 2 * CPI) begin : g_chk_size
    $error("INSTR_MEM_SIZE must be a power of two and at least 2*CPI");
  end

  imem_state_t         r_state;
  logic [AW-1:0]       r_ptr;
  logic [AW:0]         r_prog_len;
  logic                r_load_done;
  logic [WORD_LEN-1:0] r_instr;
  logic                r_instr_valid;
  logic                r_fetch_fault;

  logic                w_accept;
  logic                w_we;
  logic [AW-1:0]       w_a;
  logic [AW:0]         w_a_end;
  logic                w_upper_nz;
  logic                w_misaligned;
  logic                w_past_end;
  logic                w_fault;
  logic [WORD_LEN-1:0] w_rdata;

  // LoadStart has priority: a byte presented alongside it is dropped.
  assign w_accept = (r_state == LOAD) && LoadValid;
  assign w_we     = w_accept && !LoadStart;

  instr_mem_loadable_array #(
    .CELL_W (MEM_CELL_SIZE),
    .DEPTH  (INSTR_MEM_SIZE),
    .CPI    (CPI),
    .AW     (AW)
  ) u_array (
    .i_clk   (Clock),
    .i_we    (w_we),
    .i_waddr (r_ptr),
    .i_wdata (LoadData),
    .i_raddr (w_a),
    .o_rdata (w_rdata)
  );

  assign w_a = Addr[AW-1:0];

  if (WORD_LEN > AW) begin : g_upper
    assign w_upper_nz = |Addr[WORD_LEN-1:AW];
  end else begin : g_no_upper
    assign w_upper_nz = 1'b0;
  end

  assign w_misaligned = (Addr % WORD_LEN'(CPI)) != '0;
  assign w_a_end      = {1'b0, w_a} + (AW+1)'(CPI);
  assign w_past_end   = w_a_end > r_prog_len;
  assign w_fault      = (r_state != RUN) || w_misaligned || w_upper_nz || w_past_end;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_state     <= EMPTY;
      r_ptr       <= '0;
      r_prog_len  <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      if (LoadStart) begin
        r_state    <= LOAD;
        r_ptr      <= '0;
        r_prog_len <= '0;
      end else if (w_accept) begin
        r_ptr      <= r_ptr + AW'(1);
        r_prog_len <= {1'b0, r_ptr} + (AW+1)'(1);
        if (LoadLast || r_ptr == AW'(INSTR_MEM_SIZE - 1)) begin
          r_state     <= RUN;
          r_load_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_instr       <= WORD_LEN'(NOOP);
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else if (FetchEn) begin
      r_instr_valid <= 1'b1;
      r_fetch_fault <= w_fault;
      r_instr       <= w_fault ? WORD_LEN'(NOOP) : w_rdata;
    end else begin
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
    end
  end

  assign LoadReady   = (r_state == LOAD);
  assign Busy        = (r_state != RUN);
  assign LoadDone    = r_load_done;
  assign ProgLen     = r_prog_len;
  assign Instruction = r_instr;
  assign InstrValid  = r_instr_valid;
  assign FetchFault  = r_fetch_fault;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed vector table, corner sequences and
// randomized traffic checked against a behavioural model of the memory.
module tb_instr_mem_loadable;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        LoadStart, LoadValid, LoadLast, FetchEn;
  logic [7:0]  LoadData;
  logic [15:0] Addr;
  logic        LoadReady, LoadDone, Busy, InstrValid, FetchFault;
  logic [8:0]  ProgLen;
  logic [15:0] Instruction;

  always #5 Clock = ~Clock;

  instr_mem_loadable dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .LoadStart   (LoadStart),
    .LoadValid   (LoadValid),
    .LoadData    (LoadData),
    .LoadLast    (LoadLast),
    .LoadReady   (LoadReady),
    .LoadDone    (LoadDone),
    .ProgLen     (ProgLen),
    .Busy        (Busy),
    .FetchEn     (FetchEn),
    .Addr        (Addr),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .FetchFault  (FetchFault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: program bytes in an array, length as a plain integer.
  localparam int ST_EMPTY = 0, ST_LOAD = 1, ST_RUN = 2;
  localparam int MEM_CELLS = 256;
  int          m_state = ST_EMPTY;
  int          m_ptr   = 0;
  int          m_len   = 0;
  logic [7:0]  m_mem [MEM_CELLS];
  logic [15:0] m_instr  = 16'h0;
  bit          m_ivalid = 1'b0;
  bit          m_fault  = 1'b0;
  bit          m_done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rstn, input bit start, input bit valid,
                      input logic [7:0] data, input bit last,
                      input bit fetch, input logic [15:0] addr);
    bit f;
    @(negedge Clock);
    nReset    = rstn;
    LoadStart = start;
    LoadValid = valid;
    LoadData  = data;
    LoadLast  = last;
    FetchEn   = fetch;
    Addr      = addr;
    @(posedge Clock);
    if (!rstn) begin
      m_state = ST_EMPTY; m_ptr = 0; m_len = 0;
      m_done = 0; m_ivalid = 0; m_fault = 0; m_instr = 16'h0;
    end else begin
      if (fetch) begin
        f = (m_state != ST_RUN) || (addr % 2 != 0) || (addr >= 16'd256) ||
            (int'(addr) + 2 > m_len);
        m_ivalid = 1;
        m_fault  = f;
        m_instr  = f ? 16'h0 : {m_mem[int'(addr)], m_mem[int'(addr) + 1]};
      end else begin
        m_ivalid = 0;
        m_fault  = 0;
      end
      m_done = 0;
      if (start) begin
        m_state = ST_LOAD; m_ptr = 0; m_len = 0;
      end else if (m_state == ST_LOAD && valid) begin
        m_mem[m_ptr] = data;
        m_ptr++;
        m_len = m_ptr;
        if (last || m_ptr == MEM_CELLS) begin
          m_state = ST_RUN;
          m_done  = 1;
        end
      end
    end
    #1;
    chk("InstrValid",  32'(InstrValid),  32'(m_ivalid));
    chk("FetchFault",  32'(FetchFault),  32'(m_fault));
    chk("Instruction", 32'(Instruction), 32'(m_instr));
    chk("LoadDone",    32'(LoadDone),    32'(m_done));
    chk("ProgLen",     32'(ProgLen),     32'(m_len));
    chk("Busy",        32'(Busy),        32'(m_state != ST_RUN));
    chk("LoadReady",   32'(LoadReady),   32'(m_state == ST_LOAD));
  endtask

  task automatic idle();
    step(1, 0, 0, 8'h00, 0, 0, 16'h0);
  endtask

  typedef struct {
    bit          start, valid;
    logic [7:0]  data;
    bit          last, fetch;
    logic [15:0] addr;
    bit          e_valid, e_fault;
    logic [15:0] e_instr;
    bit          e_done;
    int          e_len;
    bit          e_busy;
  } vec_t;

  function automatic vec_t mk(bit s, bit v, logic [7:0] d, bit l, bit fe, logic [15:0] a,
                              bit ev, bit ef, logic [15:0] ei, bit ed, int el, bit eb);
    vec_t r;
    r.start = s; r.valid = v; r.data = d; r.last = l; r.fetch = fe; r.addr = a;
    r.e_valid = ev; r.e_fault = ef; r.e_instr = ei; r.e_done = ed; r.e_len = el; r.e_busy = eb;
    return r;
  endfunction

  vec_t       tbl [22];
  logic [7:0] full_bytes [256];

  initial begin
    //            st vl data  lst fe addr     | vld flt instr    dn len busy
    tbl[0]  = mk(0, 0, 8'h00, 0, 1, 16'h0000,  1, 1, 16'h0000, 0, 0, 1);
    tbl[1]  = mk(1, 0, 8'h00, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 1);
    tbl[2]  = mk(0, 1, 8'h01, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 1, 1);
    tbl[3]  = mk(0, 1, 8'hF9, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 2, 1);
    tbl[4]  = mk(0, 0, 8'hEE, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 2, 1);
    tbl[5]  = mk(0, 1, 8'h00, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 3, 1);
    tbl[6]  = mk(0, 1, 8'h0B, 1, 0, 16'h0000,  0, 0, 16'h0000, 1, 4, 0);
    tbl[7]  = mk(0, 0, 8'h00, 0, 1, 16'h0000,  1, 0, 16'h01F9, 0, 4, 0);
    tbl[8]  = mk(0, 0, 8'h00, 0, 1, 16'h0002,  1, 0, 16'h000B, 0, 4, 0);
    tbl[9]  = mk(0, 0, 8'h00, 0, 1, 16'h0001,  1, 1, 16'h0000, 0, 4, 0);
    tbl[10] = mk(0, 0, 8'h00, 0, 1, 16'h0004,  1, 1, 16'h0000, 0, 4, 0);
    tbl[11] = mk(0, 0, 8'h00, 0, 1, 16'h0100,  1, 1, 16'h0000, 0, 4, 0);
    tbl[12] = mk(0, 0, 8'h00, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 4, 0);
    tbl[13] = mk(0, 0, 8'h00, 0, 1, 16'h0002,  1, 0, 16'h000B, 0, 4, 0);
    tbl[14] = mk(0, 0, 8'h00, 0, 0, 16'h0000,  0, 0, 16'h000B, 0, 4, 0);
    tbl[15] = mk(1, 0, 8'h00, 0, 0, 16'h0000,  0, 0, 16'h000B, 0, 0, 1);
    tbl[16] = mk(0, 0, 8'hAA, 1, 1, 16'h0000,  1, 1, 16'h0000, 0, 0, 1);
    tbl[17] = mk(1, 1, 8'h55, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 1);
    tbl[18] = mk(0, 1, 8'h77, 0, 0, 16'h0000,  0, 0, 16'h0000, 0, 1, 1);
    tbl[19] = mk(0, 1, 8'h12, 1, 0, 16'h0000,  0, 0, 16'h0000, 1, 2, 0);
    tbl[20] = mk(0, 0, 8'h00, 0, 1, 16'h0000,  1, 0, 16'h7712, 0, 2, 0);
    tbl[21] = mk(0, 0, 8'h00, 0, 1, 16'h0002,  1, 1, 16'h0000, 0, 2, 0);

    nReset = 0; LoadStart = 0; LoadValid = 0; LoadData = 0;
    LoadLast = 0; FetchEn = 0; Addr = 0;

    step(0, 0, 0, 8'h00, 0, 0, 16'h0);
    step(0, 1, 1, 8'h5A, 1, 1, 16'h0);
    chk("rst_busy",  32'(Busy),        32'd1);
    chk("rst_len",   32'(ProgLen),     32'd0);
    chk("rst_ready", 32'(LoadReady),   32'd0);
    chk("rst_ivld",  32'(InstrValid),  32'd0);
    chk("rst_instr", 32'(Instruction), 32'd0);

    for (int i = 0; i < 22; i++) begin
      step(1, tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].fetch, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(InstrValid),  32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_fault", i), 32'(FetchFault),  32'(tbl[i].e_fault));
      chk($sformatf("tbl%0d_instr", i), 32'(Instruction), 32'(tbl[i].e_instr));
      chk($sformatf("tbl%0d_done",  i), 32'(LoadDone),    32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_len",   i), 32'(ProgLen),     32'(tbl[i].e_len));
      chk($sformatf("tbl%0d_busy",  i), 32'(Busy),        32'(tbl[i].e_busy));
    end

    // Full-memory load without LoadLast: auto-completes after the last cell.
    step(1, 1, 0, 8'h00, 0, 0, 16'h0);
    for (int i = 0; i < 256; i++) begin
      full_bytes[i] = 8'($urandom);
      step(1, 0, 1, full_bytes[i], 0, 0, 16'h0);
      if (i == 254) chk("full_not_done_254", 32'(LoadDone), 32'd0);
    end
    chk("full_done", 32'(LoadDone), 32'd1);
    chk("full_len",  32'(ProgLen),  32'd256);
    step(1, 0, 0, 8'h00, 0, 1, 16'd254);
    chk("full_fetch254", 32'(Instruction), 32'({full_bytes[254], full_bytes[255]}));
    chk("full_fault254", 32'(FetchFault),  32'd0);
    step(1, 0, 0, 8'h00, 0, 1, 16'd0);
    chk("full_fetch0", 32'(Instruction), 32'({full_bytes[0], full_bytes[1]}));

    // Reset part-way through a load, then reload a short program.
    step(1, 1, 0, 8'h00, 0, 0, 16'h0);
    step(1, 0, 1, 8'h11, 0, 0, 16'h0);
    step(1, 0, 1, 8'h22, 0, 0, 16'h0);
    step(1, 0, 1, 8'h33, 0, 0, 16'h0);
    step(0, 0, 1, 8'h44, 0, 0, 16'h0);
    chk("midrst_len",  32'(ProgLen), 32'd0);
    chk("midrst_busy", 32'(Busy),    32'd1);
    step(1, 0, 0, 8'h00, 0, 1, 16'h0);
    chk("midrst_fault", 32'(FetchFault), 32'd1);
    step(1, 1, 0, 8'h00, 0, 0, 16'h0);
    step(1, 0, 1, 8'hA5, 0, 0, 16'h0);
    step(1, 0, 1, 8'h3C, 1, 0, 16'h0);
    step(1, 0, 0, 8'h00, 0, 1, 16'h0);
    chk("reload_instr", 32'(Instruction), 32'h0000A53C);
    chk("reload_fault", 32'(FetchFault),  32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 900; i++) begin
      bit          r_n, s, v, l, fe;
      logic [15:0] a;
      int          sel;
      r_n = ($urandom_range(0, 299) != 0);
      s   = ($urandom_range(0, 39) == 0);
      v   = 1'($urandom);
      l   = ($urandom_range(0, 19) == 0);
      fe  = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 16'(2 * $urandom_range(0, 24));
      else if (sel < 8) a = 16'($urandom) & 16'h01FF;
      else              a = 16'($urandom);
      step(r_n, s, v, 8'($urandom), l, fe, a);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
